// File: rtl/isa_packer_pkg.sv
// Shared definitions for the ISA loader: FSM state encoding and the default
// pad/port widths, also used by the CCU side.
package isa_packer_pkg;

  localparam int IF_WIDTH_DEF   = 16;
  localparam int PORT_WIDTH_DEF = 96;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FNH  = 2'd2
  } state_e;

endpackage

// File: rtl/itf_pipe_reg.sv
// One-entry valid/ready hold register. Accepts a new entry whenever it is
// empty or its current entry leaves in the same cycle; holds data stable
// while the consumer stalls.
module itf_pipe_reg #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  // Next-entry selection: load on free slot, otherwise hold.
  always_comb begin
    in_rdy = !vld_q || out_rdy;
    vld_d  = vld_q;
    dat_d  = dat_q;
    if (in_rdy) begin
      vld_d = in_vld;
      if (in_vld) begin
        dat_d = in_dat;
      end
    end
  end

  // Entry register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/isa_packer.sv
// ISA loader: packs IF_WIDTH pad beats little-endian into PORT_WIDTH ISA
// words and hands them to the CCU through a one-entry output register.
// A completed word that cannot move on waits in the pack register, which
// throttles the pad side until the output register frees.
module isa_packer
  import isa_packer_pkg::*;
#(
  parameter int IF_WIDTH   = IF_WIDTH_DEF,
  parameter int PORT_WIDTH = PORT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  TOPITF_Start,
  input  logic [15:0]           TOPITF_NumWord,
  input  logic [IF_WIDTH-1:0]   PADITF_Dat,
  input  logic                  PADITF_DatVld,
  output logic                  ITFPAD_DatRdy,
  output logic [PORT_WIDTH-1:0] ITFCCU_Dat,
  output logic                  ITFCCU_DatVld,
  input  logic                  CCUITF_DatRdy,
  output logic                  ITFTOP_Fnh,
  output logic                  ITFTOP_Busy
);

  localparam int BEATS = PORT_WIDTH / IF_WIDTH;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  state_e                state_q, state_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [PORT_WIDTH-1:0] pack_q, pack_d;
  logic                  cmpl_q, cmpl_d;
  logic [15:0]           num_word_q, num_word_d;
  logic [15:0]           words_packed_q, words_packed_d;
  logic [15:0]           words_sent_q, words_sent_d;

  logic                  pad_rdy;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  out_fire;
  logic [PORT_WIDTH-1:0] pack_ins;
  logic                  pipe_in_vld;
  logic [PORT_WIDTH-1:0] pipe_in_dat;
  logic                  pipe_in_rdy;
  logic                  ccu_vld;
  logic [PORT_WIDTH-1:0] ccu_dat;

  // Next-state, packing and counter logic.
  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    pack_d         = pack_q;
    cmpl_d         = cmpl_q;
    num_word_d     = num_word_q;
    words_packed_d = words_packed_q;
    words_sent_d   = words_sent_q;

    pad_rdy   = (state_q == ST_LOAD) && !cmpl_q && (words_packed_q < num_word_q);
    beat_fire = PADITF_DatVld && pad_rdy;
    last_beat = beat_fire && (beat_cnt_q == LAST_BEAT);
    out_fire  = ccu_vld && CCUITF_DatRdy;

    // Word as it stands with the current beat dropped into its slot.
    pack_ins = pack_q;
    pack_ins[int'(beat_cnt_q) * IF_WIDTH +: IF_WIDTH] = PADITF_Dat;

    // A parked complete word has priority; otherwise a word finishing now.
    pipe_in_vld = cmpl_q || last_beat;
    pipe_in_dat = cmpl_q ? pack_q : pack_ins;

    unique case (state_q)
      ST_IDLE: begin
        if (TOPITF_Start) begin
          num_word_d     = TOPITF_NumWord;
          words_packed_d = '0;
          words_sent_d   = '0;
          beat_cnt_d     = '0;
          cmpl_d         = 1'b0;
          state_d        = (TOPITF_NumWord == 16'd0) ? ST_FNH : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat_fire) begin
          pack_d     = pack_ins;
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
        if (last_beat) begin
          words_packed_d = words_packed_q + 16'd1;
          cmpl_d         = !pipe_in_rdy;
        end else if (cmpl_q && pipe_in_rdy) begin
          cmpl_d = 1'b0;
        end
        if (out_fire) begin
          words_sent_d = words_sent_q + 16'd1;
          if (words_sent_q == num_word_q - 16'd1) begin
            state_d = ST_FNH;
          end
        end
      end
      ST_FNH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and pack registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      beat_cnt_q     <= '0;
      pack_q         <= '0;
      cmpl_q         <= 1'b0;
      num_word_q     <= '0;
      words_packed_q <= '0;
      words_sent_q   <= '0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      pack_q         <= pack_d;
      cmpl_q         <= cmpl_d;
      num_word_q     <= num_word_d;
      words_packed_q <= words_packed_d;
      words_sent_q   <= words_sent_d;
    end
  end

  itf_pipe_reg #(
    .WIDTH (PORT_WIDTH)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (pipe_in_vld),
    .in_dat  (pipe_in_dat),
    .in_rdy  (pipe_in_rdy),
    .out_vld (ccu_vld),
    .out_dat (ccu_dat),
    .out_rdy (CCUITF_DatRdy)
  );

  assign ITFPAD_DatRdy = pad_rdy;
  assign ITFCCU_DatVld = ccu_vld;
  assign ITFCCU_Dat    = ccu_dat;
  assign ITFTOP_Fnh    = (state_q == ST_FNH);
  assign ITFTOP_Busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_isa_packer.sv
// Bench for isa_packer: a word-level model (beat list, words expected =
// consecutive groups of accepted beats, two words of storage) predicts the
// handshake outputs every cycle; scenario tasks add directed checks.
module tb_isa_packer;

  localparam int IFW = 16;
  localparam int PW  = 96;
  localparam int B   = PW / IFW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [15:0]    numword = '0;
  logic [IFW-1:0] pad_dat = '0;
  logic           pad_vld = 1'b0;
  logic           ccu_rdy = 1'b0;
  logic           pad_rdy, ccu_vld, fnh, busy;
  logic [PW-1:0]  ccu_dat;

  isa_packer #(.IF_WIDTH(IFW), .PORT_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .TOPITF_Start(start), .TOPITF_NumWord(numword),
    .PADITF_Dat(pad_dat), .PADITF_DatVld(pad_vld), .ITFPAD_DatRdy(pad_rdy),
    .ITFCCU_Dat(ccu_dat), .ITFCCU_DatVld(ccu_vld), .CCUITF_DatRdy(ccu_rdy),
    .ITFTOP_Fnh(fnh), .ITFTOP_Busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int             m_n = 0, m_acc = 0, m_sent = 0;
  bit             m_active = 0, m_fnh = 0;
  logic [IFW-1:0] m_beats[$];

  // Observed / expected values of the last sampled cycle
  logic          o_rdy, o_vld, o_fnh, o_busy;
  logic [PW-1:0] o_dat;
  logic          e_rdy, e_vld, e_fnh, e_busy, e_xfer;
  logic [PW-1:0] e_word;
  bit            acc_now;

  function automatic logic [PW-1:0] exp_word(int k);
    logic [PW-1:0] w = '0;
    for (int b = 0; b < B; b++)
      if (k * B + b < m_beats.size()) w[b*IFW +: IFW] = m_beats[k*B + b];
    return w;
  endfunction

  // Sample outputs mid-cycle, predict them from the model, advance the model
  // with this cycle's handshakes, then move past the rising edge.
  task automatic step();
    bit nf;
    @(negedge clk);
    o_rdy = pad_rdy; o_vld = ccu_vld; o_dat = ccu_dat; o_fnh = fnh; o_busy = busy;
    e_rdy  = m_active && (m_acc < m_n * B) && ((m_acc / B) - m_sent < 2);
    e_vld  = m_active && ((m_acc / B) > m_sent);
    e_fnh  = m_fnh;
    e_busy = m_active || m_fnh;
    e_xfer = e_vld && ccu_rdy;
    e_word = e_vld ? exp_word(m_sent) : '0;
    acc_now = pad_vld && e_rdy;
    if (!rst_n) begin
      m_active = 0; m_fnh = 0; m_acc = 0; m_sent = 0; m_beats.delete();
      acc_now = 0;
    end else begin
      nf = 0;
      if (start && !e_busy) begin
        if (numword == 16'd0) nf = 1;
        else begin
          m_active = 1; m_n = int'(numword); m_acc = 0; m_sent = 0; m_beats.delete();
        end
      end
      if (acc_now) begin m_beats.push_back(pad_dat); m_acc++; end
      if (e_xfer) begin
        m_sent++;
        if (m_sent == m_n) begin m_active = 0; nf = 1; end
      end
      m_fnh = nf;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 0; pad_vld = 1; ccu_rdy = 1; start = 0;
    step(); step();
    total++; if ({o_rdy, o_vld, o_fnh, o_busy} !== 4'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0000", {o_rdy, o_vld, o_fnh, o_busy}); end
    total++; if (o_dat !== '0) begin bad++; $display("FAIL reset_dat got=%h exp=0", o_dat); end
    rst_n = 1; pad_vld = 0;
    step();
    total++; if ({o_rdy, o_vld, o_fnh, o_busy} !== 4'b0) begin bad++; $display("FAIL idle_ctrl got=%b exp=0000", {o_rdy, o_vld, o_fnh, o_busy}); end
  endtask

  task automatic test_basic();
    logic [PW-1:0] got[$];
    int xc[$];
    int fc = -1;
    logic [15:0] nxt = 16'd1;
    numword = 16'd2; start = 1; pad_vld = 1; pad_dat = nxt; ccu_rdy = 1;
    for (int c = 0; c < 40 && fc < 0; c++) begin
      step();
      total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL basic_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
      total++; if (o_vld !== e_vld) begin bad++; $display("FAIL basic_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
      total++; if ({o_fnh, o_busy} !== {e_fnh, e_busy}) begin bad++; $display("FAIL basic_fnh_busy c=%0d got=%b exp=%b", c, {o_fnh, o_busy}, {e_fnh, e_busy}); end
      if (e_xfer) begin total++; if (o_dat !== e_word) begin bad++; $display("FAIL basic_word c=%0d got=%h exp=%h", c, o_dat, e_word); end end
      if (o_vld && ccu_rdy) begin got.push_back(o_dat); xc.push_back(c); end
      if (o_fnh) fc = c;
      if (acc_now) nxt++;
      pad_dat = nxt;
    end
    pad_vld = 0;
    total++; if (got.size() != 2 || fc < 0) begin bad++; $display("FAIL basic_count got=%0d fnh_cyc=%0d exp=2 words and fnh", got.size(), fc); end
    if (got.size() == 2) begin
      total++; if (got[0] !== 96'h000600050004000300020001) begin bad++; $display("FAIL basic_w0 got=%h exp=000600050004000300020001", got[0]); end
      total++; if (got[1] !== 96'h000C000B000A000900080007) begin bad++; $display("FAIL basic_w1 got=%h exp=000C000B000A000900080007", got[1]); end
      total++; if (xc[0] != 7 || xc[1] - xc[0] != B) begin bad++; $display("FAIL basic_timing got=%0d,%0d exp=7,13", xc[0], xc[1]); end
      total++; if (fc != xc[1] + 1) begin bad++; $display("FAIL basic_fnh_cyc got=%0d exp=%0d", fc, xc[1] + 1); end
    end
  endtask

  task automatic test_zero();
    numword = 16'd0; start = 1; pad_vld = 1; ccu_rdy = 1;
    step();
    step();
    total++; if ({o_fnh, o_busy, o_rdy, o_vld} !== 4'b1100) begin bad++; $display("FAIL zero_fnh got=%b exp=1100", {o_fnh, o_busy, o_rdy, o_vld}); end
    step();
    total++; if ({o_fnh, o_busy, o_rdy, o_vld} !== 4'b0000) begin bad++; $display("FAIL zero_idle got=%b exp=0000", {o_fnh, o_busy, o_rdy, o_vld}); end
    pad_vld = 0;
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] held = '0;
    bit hv = 0;
    int nx = 0;
    bit done = 0;
    numword = 16'd3; start = 1; pad_vld = 1; pad_dat = IFW'($urandom); ccu_rdy = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step();
      total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
      total++; if (o_vld !== e_vld) begin bad++; $display("FAIL bp_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
      total++; if ({o_fnh, o_busy} !== {e_fnh, e_busy}) begin bad++; $display("FAIL bp_fnh_busy c=%0d got=%b exp=%b", c, {o_fnh, o_busy}, {e_fnh, e_busy}); end
      if (e_xfer) begin total++; if (o_dat !== e_word) begin bad++; $display("FAIL bp_word c=%0d got=%h exp=%h", c, o_dat, e_word); end end
      if (hv) begin total++; if (o_vld !== 1'b1 || o_dat !== held) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, o_vld, o_dat, held); end end
      if (c == 19) begin total++; if (o_rdy !== 1'b0 || m_acc != 2 * B) begin bad++; $display("FAIL bp_stall got=rdy %b beats %0d exp=rdy 0 beats %0d", o_rdy, m_acc, 2 * B); end end
      if (o_vld && !ccu_rdy) begin hv = 1; held = o_dat; end else hv = 0;
      if (o_vld && ccu_rdy) nx++;
      if (o_fnh) done = 1;
      if (acc_now) pad_dat = IFW'($urandom);
      ccu_rdy = (c + 1 >= 20);
    end
    pad_vld = 0;
    total++; if (nx != 3 || !done) begin bad++; $display("FAIL bp_words got=%0d done=%0d exp=3 done=1", nx, done); end
  endtask

  task automatic test_overflow();
    int taken = 0, fn = 0;
    bit late_rdy = 0;
    numword = 16'd1; start = 1; pad_vld = 1; pad_dat = IFW'($urandom); ccu_rdy = 1;
    for (int c = 0; c < 20; c++) begin
      step();
      total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL ovf_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
      if (e_xfer) begin total++; if (o_dat !== e_word) begin bad++; $display("FAIL ovf_word c=%0d got=%h exp=%h", c, o_dat, e_word); end end
      if (pad_vld && o_rdy) taken++;
      if (c > B && o_rdy) late_rdy = 1;
      if (o_fnh) fn++;
      pad_dat = IFW'($urandom);
      pad_vld = (c < 16);
    end
    total++; if (taken != B) begin bad++; $display("FAIL ovf_taken got=%0d exp=%0d", taken, B); end
    total++; if (late_rdy || fn != 1) begin bad++; $display("FAIL ovf_after got=rdy %0d fnh %0d exp=rdy 0 fnh 1", late_rdy, fn); end
  endtask

  task automatic test_start_ignored();
    int nx = 0;
    bit done = 0;
    numword = 16'd5; start = 1; pad_vld = 1; pad_dat = IFW'($urandom); ccu_rdy = 1;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL ign_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
      total++; if (o_vld !== e_vld) begin bad++; $display("FAIL ign_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
      total++; if ({o_fnh, o_busy} !== {e_fnh, e_busy}) begin bad++; $display("FAIL ign_fnh_busy c=%0d got=%b exp=%b", c, {o_fnh, o_busy}, {e_fnh, e_busy}); end
      if (e_xfer) begin total++; if (o_dat !== e_word) begin bad++; $display("FAIL ign_word c=%0d got=%h exp=%h", c, o_dat, e_word); end end
      if (o_vld && ccu_rdy) nx++;
      if (o_fnh) done = 1;
      pad_dat = IFW'($urandom);
      pad_vld = ($urandom_range(0, 3) != 0);
      if (c == 10) begin start = 1; numword = 16'd2; end
    end
    pad_vld = 0;
    total++; if (nx != 5 || !done) begin bad++; $display("FAIL ign_words got=%0d done=%0d exp=5 done=1", nx, done); end
  endtask

  task automatic test_midreset();
    logic [15:0] nxt = 16'h00A0;
    bit done = 0;
    logic [PW-1:0] w = '0;
    numword = 16'd2; start = 1; pad_vld = 1; pad_dat = IFW'($urandom); ccu_rdy = 1;
    for (int c = 0; c < 20 && m_acc < 3; c++) begin
      step();
      pad_dat = IFW'($urandom);
    end
    rst_n = 0;
    step();
    rst_n = 1; pad_vld = 0;
    step();
    total++; if ({o_rdy, o_vld, o_fnh, o_busy} !== 4'b0 || o_dat !== '0) begin bad++; $display("FAIL mrst_out got=%b/%h exp=0000/0", {o_rdy, o_vld, o_fnh, o_busy}, o_dat); end
    numword = 16'd1; start = 1; pad_vld = 1; pad_dat = nxt;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL mrst_rdy c=%0d got=%b exp=%b", c, o_rdy, e_rdy); end
      total++; if (o_vld !== e_vld) begin bad++; $display("FAIL mrst_vld c=%0d got=%b exp=%b", c, o_vld, e_vld); end
      if (o_vld && ccu_rdy) w = o_dat;
      if (o_fnh) done = 1;
      if (acc_now) nxt++;
      pad_dat = nxt;
    end
    pad_vld = 0;
    total++; if (w !== 96'h00A500A400A300A200A100A0 || !done) begin bad++; $display("FAIL mrst_word got=%h done=%0d exp=00A500A400A300A200A100A0 done=1", w, done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit done = 0;
      numword = 16'($urandom_range(1, 4)); start = 1;
      pad_vld = 1; pad_dat = IFW'($urandom); ccu_rdy = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 600 && !done; c++) begin
        step();
        total++; if (o_rdy !== e_rdy) begin bad++; $display("FAIL rnd_rdy it=%0d c=%0d got=%b exp=%b", it, c, o_rdy, e_rdy); end
        total++; if (o_vld !== e_vld) begin bad++; $display("FAIL rnd_vld it=%0d c=%0d got=%b exp=%b", it, c, o_vld, e_vld); end
        total++; if ({o_fnh, o_busy} !== {e_fnh, e_busy}) begin bad++; $display("FAIL rnd_fnh_busy it=%0d c=%0d got=%b exp=%b", it, c, {o_fnh, o_busy}, {e_fnh, e_busy}); end
        if (e_xfer) begin total++; if (o_dat !== e_word) begin bad++; $display("FAIL rnd_word it=%0d c=%0d got=%h exp=%h", it, c, o_dat, e_word); end end
        if (o_fnh) done = 1;
        pad_dat = IFW'($urandom);
        pad_vld = ($urandom_range(0, 3) != 0);
        ccu_rdy = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 19) == 0) begin start = 1; numword = 16'($urandom_range(0, 7)); end
      end
      total++; if (!done) begin bad++; $display("FAIL rnd_timeout it=%0d got=no fnh exp=fnh", it); end
      pad_vld = 0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_overflow();
    test_start_ignored();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
